id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
// - Parametrised ID->EX pipeline register with valid/ready handshake, flush and stall counter.
// - Sits between the decode/register-read stage and the ALU stage.
// - Carries control bits, register addresses, both operands and the sign-extended immediate.
// - Replaces the free-running latch with a flow-controlled stage; optional skid entry.
// PARAMETERS
// - DATA_W      32  width of rd1/rd2/imm operands
// - REG_ADDR_W   5  width of rs/rt/rd register addresses
// - ALU_CTRL_W   4  width of ALU control field
// - CNT_W       16  width of saturating stall counter
// PORTS
// - clk          in   1           rising-edge clock; single clock domain
// - rst_n        in   1           synchronous, active-low reset
// - flush        in   1           kill all held entries (branch/hazard bubble)
// - cnt_clr      in   1           synchronous clear of stall_cnt
// - in_valid     in   1           ID stage presents a valid bundle
// - in_ready     out  1           stage can accept the bundle this cycle
// - reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d  in  1 each  control bits
// - alu_ctrl_d   in   ALU_CTRL_W  ALU operation
// - rs_d, rt_d, rd_d  in  REG_ADDR_W each  register addresses
// - rd1_d, rd2_d, imm_d  in  DATA_W each  operands and sign-extended immediate
// - out_valid    out  1           EX-side bundle valid
// - out_ready    in   1           EX stage consumes the bundle this cycle
// - *_e          out  same as *_d  registered copies of every *_d field
// - stall_cnt    out  CNT_W       cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): out_valid=0; every *_e=0; stall_cnt=0; skid entry empty.
// - Transfer in:  in_valid & in_ready at posedge. Transfer out: out_valid & out_ready at posedge.
// - Latency: bundle accepted at edge N appears on *_e after edge N; out_valid=1 from then.
// - Held outputs stay stable while out_valid & ~out_ready.
// - Bubble safety: reg_write_e and mem_write_e are 0 whenever out_valid=0.
// - Other *_e fields keep their last value when out_valid=0.
// - flush=1: out_valid<=0, skid emptied, in_ready=0 that cycle.
//   Flush overrides any simultaneous in/out transfer; no bundle is loaded.
// - Simultaneous in and out transfer: new bundle loaded, out_valid stays 1 (full throughput).
// - Out transfer without in transfer: out_valid<=0.
// - stall_cnt: +1 each cycle with out_valid & ~out_ready.
//   Saturates at 2^CNT_W-1 (no wrap). cnt_clr has priority over increment. Not affected by flush.
// CONFIGURATION
// - Macro IDEX_SKID_EN.
// - Undefined: single entry. in_ready = ~flush & (~out_valid | out_ready), combinational from out_ready.
// - Defined: main + skid entry; in_ready is a register (=skid empty), with no comb path out_ready->in_ready.
//   - States: EMPTY (out_valid=0), FULL (main only), SKID (main+skid).
//   - EMPTY --in--> FULL.
//   - FULL --in & ~out_ready--> SKID: bundle parked in skid, in_ready<=0.
//   - FULL --out & ~in--> EMPTY. FULL --in & out--> FULL (main reloaded).
//   - SKID --out_ready--> FULL: main<=skid, in_ready<=1. No input accepted in SKID.
//   - flush from any state -> EMPTY. Bundle order is preserved.
// TESTING
// - Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, all *_e=0, stall_cnt=0.
// - Streaming: out_ready=1, 4 bundles rd1_d=1..4, one per cycle -> rd1_e=1,2,3,4 on consecutive cycles; in_ready held 1.
// - Backpressure: load rd1_d=0xA5, out_ready=0 for 5 cycles -> rd1_e stays 0xA5; stall_cnt=5.
//   Without skid, in_ready=0 during the stall. With skid, a second bundle 0x5A parks, then
//   emerges right after 0xA5 once out_ready=1.
// - Flush: stage full with reg_write_e=1, assert flush with in_valid=1 -> next cycle out_valid=0,
//   reg_write_e=0, mem_write_e=0; the input bundle is not loaded.
// - Saturation: CNT_W=3, hold a stall 10 cycles -> stall_cnt=7; cnt_clr=1 -> 0 next cycle.
// - Simultaneous: out_valid=1, out_ready=1, in_valid=1 with rs_d=5'd9 -> rs_e=9, out_valid stays 1.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: signal bundle between the ID stage, the ID->EX pipeline
// register and the EX stage.
//   control : flush, cnt_clr
//   ID side : in_valid/in_ready handshake plus every *_d field
//   EX side : out_valid/out_ready handshake plus every *_e field, stall_cnt
// modport master = environment (ID/EX stages), modport slave = pipeline register.
// Parameters must match those of the id_ex_pipe_reg instance attached to it.
interface id_ex_pipe_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned CNT_W      = 16
);
  logic                  flush;
  logic                  cnt_clr;
  logic                  in_valid;
  logic                  in_ready;
  logic                  reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d;
  logic [ALU_CTRL_W-1:0] alu_ctrl_d;
  logic [REG_ADDR_W-1:0] rs_d, rt_d, rd_d;
  logic [DATA_W-1:0]     rd1_d, rd2_d, imm_d;
  logic                  out_valid;
  logic                  out_ready;
  logic                  reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e;
  logic [ALU_CTRL_W-1:0] alu_ctrl_e;
  logic [REG_ADDR_W-1:0] rs_e, rt_e, rd_e;
  logic [DATA_W-1:0]     rd1_e, rd2_e, imm_e;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output flush, cnt_clr, in_valid, out_ready,
    output reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d,
    output alu_ctrl_d, rs_d, rt_d, rd_d, rd1_d, rd2_d, imm_d,
    input  in_ready, out_valid, stall_cnt,
    input  reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e,
    input  alu_ctrl_e, rs_e, rt_e, rd_e, rd1_e, rd2_e, imm_e
  );

  modport slave (
    input  flush, cnt_clr, in_valid, out_ready,
    input  reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d,
    input  alu_ctrl_d, rs_d, rt_d, rd_d, rd1_d, rd2_d, imm_d,
    output in_ready, out_valid, stall_cnt,
    output reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e,
    output alu_ctrl_e, rs_e, rt_e, rd_e, rd1_e, rd2_e, imm_e
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: flow-controlled ID->EX pipeline register.
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   bus        : id_ex_pipe_reg_if.slave (handshakes, *_d inputs, *_e outputs,
//                flush, cnt_clr, stall_cnt)
// Build option: define IDEX_SKID_EN to add a skid entry; in_ready then comes
// from registered state only (no combinational out_ready->in_ready path).
// Without it the stage holds a single entry and in_ready depends on out_ready.
// stall_cnt counts cycles with out_valid & ~out_ready, saturating.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned CNT_W      = 16
) (
  input logic              clk,
  input logic              rst_n,
  id_ex_pipe_reg_if.slave  bus
);

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_dst;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     imm;
  } bundle_t;

  // S_SKID is only reachable when the skid entry is built in.
  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

  state_t           state_q, state_d;
  bundle_t          in_b, main_q, main_d;
`ifdef IDEX_SKID_EN
  bundle_t          skid_q, skid_d;
`endif
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             out_valid, in_ready, xfer_in, xfer_out;

  always_comb begin
    in_b.reg_write  = bus.reg_write_d;
    in_b.mem_to_reg = bus.mem_to_reg_d;
    in_b.mem_write  = bus.mem_write_d;
    in_b.alu_src    = bus.alu_src_d;
    in_b.reg_dst    = bus.reg_dst_d;
    in_b.alu_ctrl   = bus.alu_ctrl_d;
    in_b.rs         = bus.rs_d;
    in_b.rt         = bus.rt_d;
    in_b.rd         = bus.rd_d;
    in_b.rd1        = bus.rd1_d;
    in_b.rd2        = bus.rd2_d;
    in_b.imm        = bus.imm_d;
  end

  assign out_valid = (state_q != S_EMPTY);
`ifdef IDEX_SKID_EN
  assign in_ready  = ~bus.flush & (state_q != S_SKID);
`else
  assign in_ready  = ~bus.flush & (~out_valid | bus.out_ready);
`endif
  assign xfer_in   = bus.in_valid & in_ready;
  assign xfer_out  = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef IDEX_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      S_EMPTY: begin
        if (xfer_in) begin
          main_d  = in_b;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (xfer_in && xfer_out) begin
          main_d = in_b;
`ifdef IDEX_SKID_EN
        end else if (xfer_in) begin
          skid_d  = in_b;
          state_d = S_SKID;
`endif
        end else if (xfer_out) begin
          state_d = S_EMPTY;
        end
      end
      S_SKID: begin
`ifdef IDEX_SKID_EN
        if (bus.out_ready) begin
          main_d  = skid_q;
          state_d = S_FULL;
        end
`else
        state_d = S_EMPTY;
`endif
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush wins over any transfer; main keeps its old contents so the
    // non-critical *_e fields hold their last value through the bubble.
    if (bus.flush) begin
      state_d = S_EMPTY;
      main_d  = main_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.cnt_clr)
      stall_cnt_d = '0;
    else if (out_valid && !bus.out_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
`ifdef IDEX_SKID_EN
      skid_q      <= '0;
`endif
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
`ifdef IDEX_SKID_EN
      skid_q      <= skid_d;
`endif
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.stall_cnt    = stall_cnt_q;
  // Side-effecting controls are masked so a bubble can never write.
  assign bus.reg_write_e  = main_q.reg_write & out_valid;
  assign bus.mem_write_e  = main_q.mem_write & out_valid;
  assign bus.mem_to_reg_e = main_q.mem_to_reg;
  assign bus.alu_src_e    = main_q.alu_src;
  assign bus.reg_dst_e    = main_q.reg_dst;
  assign bus.alu_ctrl_e   = main_q.alu_ctrl;
  assign bus.rs_e         = main_q.rs;
  assign bus.rt_e         = main_q.rt;
  assign bus.rd_e         = main_q.rd;
  assign bus.rd1_e        = main_q.rd1;
  assign bus.rd2_e        = main_q.rd2;
  assign bus.imm_e        = main_q.imm;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Testbench for id_ex_pipe_reg: table-driven streaming vectors, hand-written
// backpressure/flush/saturation sequences and a randomized run, all checked
// against a queue-based reference model. A second instance with CNT_W=3
// shares the stimulus to exercise stall counter saturation.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .ALU_CTRL_W(4), .CNT_W(16)) bus ();
  id_ex_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .ALU_CTRL_W(4), .CNT_W(3))  bus_s ();

  id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .ALU_CTRL_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .ALU_CTRL_W(4), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  assign bus_s.flush        = bus.flush;
  assign bus_s.cnt_clr      = bus.cnt_clr;
  assign bus_s.in_valid     = bus.in_valid;
  assign bus_s.out_ready    = bus.out_ready;
  assign bus_s.reg_write_d  = bus.reg_write_d;
  assign bus_s.mem_to_reg_d = bus.mem_to_reg_d;
  assign bus_s.mem_write_d  = bus.mem_write_d;
  assign bus_s.alu_src_d    = bus.alu_src_d;
  assign bus_s.reg_dst_d    = bus.reg_dst_d;
  assign bus_s.alu_ctrl_d   = bus.alu_ctrl_d;
  assign bus_s.rs_d         = bus.rs_d;
  assign bus_s.rt_d         = bus.rt_d;
  assign bus_s.rd_d         = bus.rd_d;
  assign bus_s.rd1_d        = bus.rd1_d;
  assign bus_s.rd2_d        = bus.rd2_d;
  assign bus_s.imm_d        = bus.imm_d;

  typedef struct packed {
    logic        reg_write, mem_to_reg, mem_write, alu_src, reg_dst;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
  } bundle_t;

  typedef struct {
    logic        iv, ordy;
    logic [31:0] rd1;
    logic [4:0]  rs;
    logic        exp_ir, exp_ov;
    logic [31:0] exp_rd1;
    logic [4:0]  exp_rs;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  bundle_t     q[$];
  bundle_t     last_e;
  int unsigned cnt_m, cnt_s;
  vec_t        vt[7];

  function automatic bundle_t cur_out();
    bundle_t b;
    b.reg_write = bus.reg_write_e;  b.mem_to_reg = bus.mem_to_reg_e;
    b.mem_write = bus.mem_write_e;  b.alu_src    = bus.alu_src_e;
    b.reg_dst   = bus.reg_dst_e;    b.alu_ctrl   = bus.alu_ctrl_e;
    b.rs = bus.rs_e;   b.rt = bus.rt_e;   b.rd = bus.rd_e;
    b.rd1 = bus.rd1_e; b.rd2 = bus.rd2_e; b.imm = bus.imm_e;
    return b;
  endfunction

  function automatic bundle_t cur_in();
    bundle_t b;
    b.reg_write = bus.reg_write_d;  b.mem_to_reg = bus.mem_to_reg_d;
    b.mem_write = bus.mem_write_d;  b.alu_src    = bus.alu_src_d;
    b.reg_dst   = bus.reg_dst_d;    b.alu_ctrl   = bus.alu_ctrl_d;
    b.rs = bus.rs_d;   b.rt = bus.rt_d;   b.rd = bus.rd_d;
    b.rd1 = bus.rd1_d; b.rd2 = bus.rd2_d; b.imm = bus.imm_d;
    return b;
  endfunction

  task automatic set_in(input bundle_t b);
    bus.reg_write_d = b.reg_write;  bus.mem_to_reg_d = b.mem_to_reg;
    bus.mem_write_d = b.mem_write;  bus.alu_src_d    = b.alu_src;
    bus.reg_dst_d   = b.reg_dst;    bus.alu_ctrl_d   = b.alu_ctrl;
    bus.rs_d = b.rs;   bus.rt_d = b.rt;   bus.rd_d = b.rd;
    bus.rd1_d = b.rd1; bus.rd2_d = b.rd2; bus.imm_d = b.imm;
  endtask

  task automatic idle();
    bus.flush = 1'b0; bus.cnt_clr = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    set_in('0);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a FIFO of capacity 1 (or 2 with the skid entry).
  function automatic logic model_in_ready();
`ifdef IDEX_SKID_EN
    return !bus.flush && (q.size() < 2);
`else
    return !bus.flush && (q.size() == 0 || bus.out_ready);
`endif
  endfunction

  task automatic model_edge();
    logic in_x, out_x;
    if (!rst_n) begin
      q.delete(); last_e = '0; cnt_m = 0; cnt_s = 0;
    end else begin
      in_x  = bus.in_valid && model_in_ready();
      out_x = (q.size() > 0) && bus.out_ready;
      if (bus.cnt_clr) begin
        cnt_m = 0; cnt_s = 0;
      end else if (q.size() > 0 && !bus.out_ready) begin
        if (cnt_m < 65535) cnt_m++;
        if (cnt_s < 7) cnt_s++;
      end
      if (bus.flush) q.delete();
      else begin
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back(cur_in());
      end
      if (q.size() > 0) last_e = q[0];
    end
  endtask

  task automatic check_model(input string tag);
    bundle_t exp;
    exp = last_e;
    if (q.size() == 0) begin exp.reg_write = 1'b0; exp.mem_write = 1'b0; end
    chk({tag, ".out_valid"}, bus.out_valid, q.size() > 0);
    chk({tag, ".e_fields"}, cur_out(), exp);
    chk({tag, ".stall_cnt"}, bus.stall_cnt, cnt_m);
    chk({tag, ".stall_cnt_w3"}, bus_s.stall_cnt, cnt_s);
  endtask

  // Inputs are driven 1 time unit after an edge; in_ready is sampled once
  // they have settled, outputs 1 unit after the next edge.
  task automatic cycle(input string tag);
    #1;
    if (rst_n) chk({tag, ".in_ready"}, bus.in_ready, model_in_ready());
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    cycle("reset");
    cycle("reset");
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bundle_t b;
    q.delete(); last_e = '0; cnt_m = 0; cnt_s = 0;

    //          iv ordy rd1    rs     ir ov exp_rd1 exp_rs
    vt[0] = '{1'b1, 1'b1, 32'd1, 5'd1, 1'b1, 1'b1, 32'd1, 5'd1};
    vt[1] = '{1'b1, 1'b1, 32'd2, 5'd2, 1'b1, 1'b1, 32'd2, 5'd2};
    vt[2] = '{1'b1, 1'b1, 32'd3, 5'd3, 1'b1, 1'b1, 32'd3, 5'd3};
    vt[3] = '{1'b1, 1'b1, 32'd4, 5'd4, 1'b1, 1'b1, 32'd4, 5'd4};
    vt[4] = '{1'b1, 1'b1, 32'd7, 5'd9, 1'b1, 1'b1, 32'd7, 5'd9};
    vt[5] = '{1'b0, 1'b1, 32'd0, 5'd0, 1'b1, 1'b0, 32'd7, 5'd9};
    vt[6] = '{1'b0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 32'd7, 5'd9};

    // Reset with in_valid high
    do_reset();
    chk("rst.out_valid", bus.out_valid, 1'b0);
    chk("rst.e_fields", cur_out(), '0);
    chk("rst.stall_cnt", bus.stall_cnt, 16'd0);

    // Streaming and simultaneous in/out transfer
    for (int unsigned i = 0; i < 7; i++) begin
      b = '0; b.rd1 = vt[i].rd1; b.rs = vt[i].rs;
      set_in(b);
      bus.in_valid = vt[i].iv; bus.out_ready = vt[i].ordy;
      #1;
      chk($sformatf("vec%0d.in_ready", i), bus.in_ready, vt[i].exp_ir);
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.out_valid", i), bus.out_valid, vt[i].exp_ov);
      chk($sformatf("vec%0d.rd1_e", i), bus.rd1_e, vt[i].exp_rd1);
      chk($sformatf("vec%0d.rs_e", i), bus.rs_e, vt[i].exp_rs);
    end

    // Backpressure, second bundle presented during the stall
    do_reset();
    b = '0; b.rd1 = 32'hA5; set_in(b);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    cycle("bp.load");
    b.rd1 = 32'h5A; set_in(b);
    for (int unsigned i = 0; i < 5; i++) begin
      #1;
`ifdef IDEX_SKID_EN
      chk("bp.in_ready", bus.in_ready, i == 0);
`else
      chk("bp.in_ready", bus.in_ready, 1'b0);
`endif
      cycle("bp.stall");
      chk("bp.rd1_held", bus.rd1_e, 32'hA5);
    end
    chk("bp.stall_cnt", bus.stall_cnt, 16'd5);
    bus.out_ready = 1'b1;
    cycle("bp.release");
    chk("bp.second_rd1", bus.rd1_e, 32'h5A);
    chk("bp.second_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    cycle("bp.drain");
    chk("bp.drained", bus.out_valid, 1'b0);

    // Flush with a bundle on the input
    do_reset();
    b = '0; b.reg_write = 1'b1; b.mem_write = 1'b1; b.rd1 = 32'h11; set_in(b);
    bus.in_valid = 1'b1;
    cycle("fl.load");
    chk("fl.loaded_rw", bus.reg_write_e, 1'b1);
    b.rd1 = 32'h22; set_in(b);
    bus.flush = 1'b1;
    #1;
    chk("fl.in_ready", bus.in_ready, 1'b0);
    cycle("fl.flush");
    chk("fl.out_valid", bus.out_valid, 1'b0);
    chk("fl.reg_write_e", bus.reg_write_e, 1'b0);
    chk("fl.mem_write_e", bus.mem_write_e, 1'b0);
    chk("fl.rd1_kept", bus.rd1_e, 32'h11);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    cycle("fl.after");
    chk("fl.still_empty", bus.out_valid, 1'b0);

    // Counter saturation on the CNT_W=3 instance, then clear
    do_reset();
    b = '0; b.rd1 = 32'h33; set_in(b);
    bus.in_valid = 1'b1;
    cycle("sat.load");
    bus.in_valid = 1'b0;
    for (int unsigned i = 0; i < 10; i++) cycle("sat.stall");
    chk("sat.w3_cnt", bus_s.stall_cnt, 3'd7);
    chk("sat.w16_cnt", bus.stall_cnt, 16'd10);
    bus.cnt_clr = 1'b1;
    cycle("sat.clr");
    chk("sat.clr_w3", bus_s.stall_cnt, 3'd0);
    chk("sat.clr_w16", bus.stall_cnt, 16'd0);
    bus.cnt_clr = 1'b0;
    cycle("sat.recount");
    chk("sat.recount_w3", bus_s.stall_cnt, 3'd1);

    // Randomized traffic against the reference model
    do_reset();
    for (int unsigned i = 0; i < 3000; i++) begin
      b.reg_write = 1'($urandom);  b.mem_to_reg = 1'($urandom);
      b.mem_write = 1'($urandom);  b.alu_src    = 1'($urandom);
      b.reg_dst   = 1'($urandom);  b.alu_ctrl   = 4'($urandom);
      b.rs = 5'($urandom); b.rt = 5'($urandom); b.rd = 5'($urandom);
      b.rd1 = $urandom; b.rd2 = $urandom; b.imm = $urandom;
      set_in(b);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.cnt_clr   = ($urandom_range(0, 29) == 0);
      rst_n         = ($urandom_range(0, 299) != 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
